// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result-side logic.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FIXUP = 2'd2
  } alu_result_state_t;

  localparam int ALU_DATA_WIDTH        = 8;
  localparam int FIXUP_TIMEOUT_DEFAULT = 4;

endpackage

// File: rtl/alu_result_register.sv
// ALU output hold register: captures adder result/carry/overflow, drives the
// system and ADL buses on request, and tracks indexed-address page crossings.
module alu_result_register
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
  parameter int FIXUP_TIMEOUT = FIXUP_TIMEOUT_DEFAULT
) (
  input  logic                  clk_IN,
  input  logic                  reset_N_IN,
  input  logic [DATA_WIDTH-1:0] aluResult_IN,
  input  logic                  carry_IN,
  input  logic                  overflow_IN,
  input  logic                  load_EN,
  input  logic                  addrMode_IN,
  input  logic                  clear_EN,
  input  logic                  systemBus_EN,
  input  logic                  adlBus_EN,
  input  logic                  pageCross_ACK,
  output logic [DATA_WIDTH-1:0] result_REG_OUT,
  output logic [DATA_WIDTH-1:0] systemBus_OUT,
  output logic                  systemBus_DRIVE,
  output logic [DATA_WIDTH-1:0] adlBus_OUT,
  output logic                  adlBus_DRIVE,
  output logic                  carry_OUT,
  output logic                  overflow_OUT,
  output logic                  valid_OUT,
  output logic                  pageCross_REQ,
  output logic                  loadDropped_OUT,
  output logic                  fixupTimeout_OUT
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(FIXUP_TIMEOUT);

  alu_result_state_t     state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_q, carry_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  tmo_q, tmo_d;
  logic                  capture;
  logic                  valid;

  always_ff @(posedge clk_IN or negedge reset_N_IN) begin
    if (!reset_N_IN) begin
      state_q    <= IDLE;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    tmo_d      = tmo_q;
    capture    = 1'b0;
    if (clear_EN) begin
      // Clear invalidates but keeps the last result visible on result_REG_OUT.
      state_d = IDLE;
      cnt_d   = '0;
      drop_d  = 1'b0;
      tmo_d   = 1'b0;
    end else if (state_q == FIXUP) begin
      if (pageCross_ACK) begin
        state_d = HOLD;
        cnt_d   = '0;
        capture = load_EN;
      end else begin
        drop_d = drop_q | load_EN;
        if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          state_d = HOLD;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else if (load_EN) begin
      capture = 1'b1;
    end
    if (capture) begin
      result_d   = aluResult_IN;
      carry_d    = carry_IN;
      overflow_d = overflow_IN;
      state_d    = (addrMode_IN & carry_IN) ? FIXUP : HOLD;
      cnt_d      = '0;
    end
  end

  // Bus drive is combinational so the held byte reaches the bus in the request cycle.
  always_comb begin
    valid            = (state_q != IDLE);
    valid_OUT        = valid;
    pageCross_REQ    = (state_q == FIXUP);
    result_REG_OUT   = result_q;
    carry_OUT        = carry_q;
    overflow_OUT     = overflow_q;
    loadDropped_OUT  = drop_q;
    fixupTimeout_OUT = tmo_q;
    systemBus_DRIVE  = systemBus_EN & valid;
    adlBus_DRIVE     = adlBus_EN & valid;
    systemBus_OUT    = systemBus_DRIVE ? result_q : '0;
    adlBus_OUT       = adlBus_DRIVE ? result_q : '0;
  end

endmodule

// File: doc/alu_result_register.md
Name: alu_result_register

Overview:
- Output-side hold register of the 6502 ALU; the counterpart of the ALU input registers.
- Captures the 8-bit adder result with its carry and overflow, then drives the held value onto the system bus and/or the address-low (ADL) bus on request.
- Tracks indexed-address page crossings: carry out of an address add raises a fixup request to the sequencer until it is acknowledged or times out.

Parameters:
- DATA_WIDTH, 8, width of result and both bus outputs.
- FIXUP_TIMEOUT, 4, cycles FIXUP may wait for pageCross_ACK before forced exit (legal range 1-255).

Ports:
- clk_IN  input  1  system clock; all state updates on rising edge.
- reset_N_IN  input  1  asynchronous, active-low reset.
- aluResult_IN  input  DATA_WIDTH  adder result.
- carry_IN  input  1  adder carry out.
- overflow_IN  input  1  adder overflow.
- load_EN  input  1  capture result/carry/overflow this edge.
- addrMode_IN  input  1  qualifies a load as an address-low computation.
- clear_EN  input  1  invalidate the held result.
- systemBus_EN  input  1  request drive onto system bus.
- adlBus_EN  input  1  request drive onto ADL bus.
- pageCross_ACK  input  1  sequencer has performed the high-byte fixup.
- result_REG_OUT  output  DATA_WIDTH  held result.
- systemBus_OUT  output  DATA_WIDTH  system bus data; 0 when not driving.
- systemBus_DRIVE  output  1  system bus driver enable.
- adlBus_OUT  output  DATA_WIDTH  ADL bus data; 0 when not driving.
- adlBus_DRIVE  output  1  ADL bus driver enable.
- carry_OUT  output  1  held carry.
- overflow_OUT  output  1  held overflow.
- valid_OUT  output  1  held result is valid.
- pageCross_REQ  output  1  high-byte fixup pending.
- loadDropped_OUT  output  1  sticky: a load arrived while in FIXUP.
- fixupTimeout_OUT  output  1  sticky: FIXUP exited by timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: every output 0; state IDLE; timeout counter 0.
- States:
  - IDLE: no valid data.
  - HOLD: valid data held.
  - FIXUP: valid data held, page cross pending.
- Outputs by state: valid_OUT=1 in HOLD and FIXUP. pageCross_REQ=1 only in FIXUP.
- Load latency: capture on the edge where load_EN=1; new data and state are visible the following cycle.
- Priority per edge: clear_EN > pageCross_ACK > load_EN.
- IDLE or HOLD with load_EN:
  - capture data;
  - go to FIXUP if addrMode_IN & carry_IN, else HOLD.
- FIXUP with load_EN and no pageCross_ACK:
  - load ignored; data unchanged;
  - loadDropped_OUT set.
- FIXUP with pageCross_ACK:
  - go to HOLD;
  - if load_EN is also 1, capture the new data and evaluate the FIXUP/HOLD rule on the new inputs; no drop flag.
- FIXUP timeout:
  - counter increments each FIXUP cycle without ACK;
  - on the cycle the counter reaches FIXUP_TIMEOUT, go to HOLD and set fixupTimeout_OUT;
  - an ACK on that same cycle wins and no flag is set;
  - counter clears on FIXUP entry and exit.
- clear_EN in any state:
  - go to IDLE; valid_OUT=0;
  - result_REG_OUT, carry_OUT and overflow_OUT retain their values;
  - pending request dropped;
  - both sticky flags cleared;
  - a simultaneous load is discarded.
- Bus drive (combinational, same cycle):
  - systemBus_DRIVE = systemBus_EN & valid_OUT;
  - adlBus_DRIVE = adlBus_EN & valid_OUT;
  - data = result_REG_OUT while driving, else 0.
  - Both buses may be driven at once.
  - Drive is allowed in FIXUP because the low byte is already correct.
  - Enables in IDLE produce no drive.
- Arithmetic: none inside the block; the result is stored verbatim. Wrap-around of the low byte is the adder's; carry_OUT records it.
- Reset mid-FIXUP: immediate return to IDLE; pageCross_REQ drops asynchronously.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_result_state_t {IDLE, HOLD, FIXUP};
  - ALU_DATA_WIDTH=8;
  - FIXUP_TIMEOUT default constant.
- No sub-module is natural; the timeout counter is small and inline.

Test Plan:
- Reset then load aluResult_IN=8'h5A, carry=0, addrMode=0 -> next cycle valid_OUT=1, result_REG_OUT=8'h5A, state HOLD, pageCross_REQ=0; systemBus_EN=1 gives systemBus_OUT=8'h5A, systemBus_DRIVE=1; adlBus_OUT=0.
- Load 8'h03, carry=1, addrMode=1 -> pageCross_REQ=1 next cycle; adlBus_EN=1 gives adlBus_OUT=8'h03; pageCross_ACK after 2 cycles -> HOLD, REQ=0, fixupTimeout_OUT=0.
- In FIXUP, load 8'hFF without ACK -> result stays 8'h03, loadDropped_OUT=1. Same cycle with ACK and load 8'hFF, carry=0 -> HOLD, result 8'hFF, no drop flag.
- FIXUP with no ACK, FIXUP_TIMEOUT=4 -> REQ high exactly 4 cycles, then HOLD with fixupTimeout_OUT=1. clear_EN -> IDLE, both flags 0, result_REG_OUT still held.
- clear_EN and load_EN (8'h77) on the same edge from HOLD -> IDLE, valid_OUT=0, result unchanged. Enables asserted give DRIVE=0 and bus outputs 0.
- Drop reset_N_IN asynchronously mid-FIXUP (between clock edges) -> all outputs 0 immediately. After release, first load behaves as in the first scenario.
